// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: round-robin sharing of one async SRAM between a write port and a read port, one fixed-length access per grant.
// Optional SRAM_ARB_STATS_EN adds saturating ack and conflict counters.
module sram_access_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
`ifdef SRAM_ARB_STATS_EN
  output logic [15:0]       o_wr_cnt,
  output logic [15:0]       o_rd_cnt,
  output logic [15:0]       o_conflict_cnt,
`endif
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);
  localparam int CW = $clog2(ACCESS_CYCLES);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic              rr_ptr, dir_q, grant_wr, any_req, last, in_acc;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CW-1:0]     cnt;
  // rr_ptr=0 favours the write port when both ports request together
  always_comb begin
    any_req  = i_wr_req || i_rd_req;
    grant_wr = i_wr_req && (!i_rd_req || !rr_ptr);
    last     = cnt == CW'(ACCESS_CYCLES - 1);
    in_acc   = state == ACCESS;
    state_n  = state == IDLE   ? (any_req ? ACCESS : IDLE) :
               state == ACCESS ? (last ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      dir_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt       <= '0;
      o_rd_data <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        addr_q <= grant_wr ? i_wr_addr : i_rd_addr;
        data_q <= i_wr_data;
        dir_q  <= grant_wr;
        rr_ptr <= grant_wr;
        cnt    <= '0;
      end
      if (in_acc) cnt <= cnt + CW'(1);
      if (in_acc && last && !dir_q) o_rd_data <= io_SRAM_DQ;
    end
  end
  // WE_N rises one cycle early so data is held past the write strobe
  assign o_SRAM_ADDR = addr_q;
  assign io_SRAM_DQ  = (in_acc && dir_q) ? data_q : {DATA_W{1'bz}};
  assign o_SRAM_CE_N = !in_acc;
  assign o_SRAM_LB_N = !in_acc;
  assign o_SRAM_UB_N = !in_acc;
  assign o_SRAM_WE_N = !(in_acc && dir_q && !last);
  assign o_SRAM_OE_N = !(in_acc && !dir_q);
  assign o_wr_ack    = state == DONE && dir_q;
  assign o_rd_ack    = state == DONE && !dir_q;
  assign o_busy      = state != IDLE;
`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_cnt       <= '0;
      o_rd_cnt       <= '0;
      o_conflict_cnt <= '0;
    end else begin
      if (o_wr_ack && o_wr_cnt != 16'hFFFF) o_wr_cnt <= o_wr_cnt + 16'd1;
      if (o_rd_ack && o_rd_cnt != 16'hFFFF) o_rd_cnt <= o_rd_cnt + 16'd1;
      if (state == IDLE && i_wr_req && i_rd_req && o_conflict_cnt != 16'hFFFF)
        o_conflict_cnt <= o_conflict_cnt + 16'd1;
    end
  end
`endif
endmodule
